// File: rtl/display_timing_480p.sv
// 640x480p60 video timing generator in the pixel clock domain.
// Idles until the PLL reports lock and drops back to idle whenever lock is lost.
module display_timing_480p #(
  parameter int   H_RES  = 640,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_RES  = 480,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int   CORDW  = 10
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             clk_locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             live_q, live_d;
  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic [15:0]      frame_count_q, frame_count_d;

  // Position sequencing: live_q separates the lock-sampling RUN cycle from the first displayed pixel
  always_comb begin
    state_d       = state_q;
    live_d        = 1'b0;
    sx_d          = '0;
    sy_d          = '0;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (clk_locked) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!clk_locked) begin
          state_d = ST_IDLE;
        end else if (!live_q) begin
          live_d        = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          live_d = 1'b1;
          if (sx_q == H_LAST) begin
            if (sy_q == V_LAST) begin
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              sy_d = sy_q + CORDW'(1);
            end
          end else begin
            sx_d = sx_q + CORDW'(1);
            sy_d = sy_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode the strobes from the next position so they register alongside it
  always_comb begin
    hsync_d = ~H_POL;
    vsync_d = ~V_POL;
    de_d    = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (live_d) begin
      hsync_d = ((sx_d >= HS_BEG) && (sx_d < HS_END)) ? H_POL : ~H_POL;
      vsync_d = ((sy_d >= VS_BEG) && (sy_d < VS_END)) ? V_POL : ~V_POL;
      de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
      line_d  = (sx_d == '0);
      frame_d = (sx_d == '0) && (sy_d == '0);
    end else begin
      hsync_d = ~H_POL;
      vsync_d = ~V_POL;
    end
  end

  // State and output registers
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      live_q        <= 1'b0;
      sx_q          <= '0;
      sy_q          <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      line_q        <= 1'b0;
      frame_q       <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      live_q        <= live_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_q        <= line_d;
      frame_q       <= frame_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line        = line_q;
  assign frame       = frame_q;
  assign frame_count = frame_count_q;

endmodule
